mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the five-stage pipeline, between the EX/MEM pipeline register and the MEM/WB register. It takes the registered ALU result, store data, control byte, destination register, exception vector and PC. It performs byte/half/word loads and stores over a req/ack data-memory port and stalls the upstream pipeline while a transfer is outstanding. It raises address-error and bus-timeout exception codes and registers its results for write-back.

## Interface
- TIMEOUT, 16: max WAIT cycles without dmem_ack before bus error; range 2..255.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- control_in  in  8  [0] bubble, [1] mem_read, [2] mem_write, [4:3] size (00 byte, 01 half, 10/11 word), [5] load sign-extend, [6] reg_write, [7] mem_to_reg.
- alu_in  in  32  effective address / ALU result.
- sw_in  in  32  store data, right-justified.
- regdst_in  in  5  destination register.
- vector_ex_in  in  5  upstream exception code, 0 = none.
- pc_in  in  32  instruction PC.
- mem_flush  in  1  discard the instruction completing this cycle.
- dmem_ack  in  1  memory transfer done; rdata valid.
- dmem_rdata  in  32  read data.
- stall_out  out  1  hold EX/MEM and earlier stages (combinational).
- dmem_req, dmem_we  out  1  request, write enable (registered).
- dmem_addr  out  32  word-aligned address {alu[31:2],2'b00}.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables.
- wb_data_out  out  32  load data or ALU result.
- control_out  out  8  forwarded control byte.
- regdst_out  out  5  forwarded destination.
- vector_mem_out  out  5  exception code.
- pc_out  out  32  forwarded PC.

## Operation
- States: IDLE, WAIT.
- mem_op = !bubble & (mem_read|mem_write) & vector_ex_in==0 & aligned.
- Aligned rules: half needs alu[0]=0; word needs alu[1:0]=0; byte is always aligned.
- IDLE, no mem_op: output registers load inputs next edge. wb_data_out = alu_in.
- IDLE, mem_op: stall_out=1. Latch addr, wdata, be and we; set dmem_req=1 at the edge; go to WAIT. Output registers load a bubble (control 8'h01, others 0).
- Misaligned access with no upstream exception: no transfer. vector = 5'd4 for a load, 5'd5 for a store. control_out clears bits [6],[2],[1].
- Nonzero vector_ex_in: no transfer; the vector passes through unchanged with the same control clearing.
- Store lanes:
  - byte: wdata={4{sw[7:0]}}, be=4'b0001<<alu[1:0].
  - half: wdata={2{sw[15:0]}}, be=alu[1]?4'b1100:4'b0011.
  - word: wdata=sw, be=4'b1111.
- Load extract: select the byte/half lane by alu[1:0], then sign-extend if [5], else zero-extend.
- WAIT: dmem_req, addr, we, be and wdata stay stable. stall_out=!dmem_ack.
- WAIT + dmem_ack: clear req, go to IDLE, register the result.
  - wb_data_out = extracted load data if mem_read, else alu.
  - The upstream register advances on the same edge.
- Cycle counter: cleared on WAIT entry, incremented each WAIT cycle.
- Counter reaching TIMEOUT without ack: drop req, go to IDLE, vector_mem_out=5'd7, control_out clears [6],[2],[1], stall released.
- Ack in the same cycle as the timeout: ack wins.
- mem_flush=1 on an output-loading edge: the output registers load a bubble.
- mem_flush during WAIT: the transfer still completes (req is held until ack or timeout), and the result is replaced by a bubble.

## Timing
- Reset values:
  - state IDLE, counter 0, stall_out 0.
  - dmem_req, dmem_we 0; dmem_addr, dmem_wdata 0; dmem_be 0.
  - wb_data_out, regdst_out, vector_mem_out, pc_out 0; control_out 8'h01.
- Non-memory and exception paths: 1-cycle latency.
- Memory op: req asserts the edge after the op is seen. The result registers on the edge ending the ack cycle. Minimum latency is 2 cycles with ack in the first req cycle.
- Reset asserted mid-WAIT: immediate return to IDLE with req=0; the transfer is abandoned.

## Test plan
- ALU op, alu_in=32'h1234, regdst=5 -> next cycle wb_data_out=32'h1234, regdst_out=5, stall_out never high.
- lb with alu=32'h103, rdata=32'h80FF_FF00, ack 2 cycles after req -> wb_data_out=32'hFFFF_FF80, stall high for 3 cycles, dmem_addr=32'h100.
- sh with alu=32'h202, sw=32'hABCD_5678 -> dmem_we=1, be=4'b1100, wdata=32'h5678_5678.
- lw at alu=32'h301 -> no req, vector_mem_out=4, control_out[6]=0. sw at 32'h302 -> vector 5.
- Load with ack never returned, TIMEOUT=16 -> req drops after 16 WAIT cycles, vector 7. Ack on cycle 16 -> normal completion.
- mem_flush during WAIT -> req held until ack, output is a bubble (8'h01). Reset mid-WAIT -> req=0 and all outputs at reset values immediately.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory-access stage with req/ack data port, stall, exceptions and MEM/WB register
// Ports: clk/reset (async, active-high); control_in/alu_in/sw_in/regdst_in/vector_ex_in/pc_in from EX/MEM;
// mem_flush discards the completing instruction; dmem_* is the data-memory req/ack port;
// stall_out holds upstream stages; *_out/wb_data_out form the MEM/WB register.
module mem_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  control_in,
    input  logic [31:0] alu_in,
    input  logic [31:0] sw_in,
    input  logic [4:0]  regdst_in,
    input  logic [4:0]  vector_ex_in,
    input  logic [31:0] pc_in,
    input  logic        mem_flush,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    output logic [31:0] wb_data_out,
    output logic [7:0]  control_out,
    output logic [4:0]  regdst_out,
    output logic [4:0]  vector_mem_out,
    output logic [31:0] pc_out
);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        flush_q, flush_d, req_q, req_d, we_q, we_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wb_q, wb_d, pc_q, pc_d;
    logic [7:0]  ctrl_q, ctrl_d;
    logic [4:0]  rd_q, rd_d, vec_q, vec_d;

    logic        is_byte, is_half, sx, aligned, access, mem_op, timeout, take, bub, flush_now;
    logic [3:0]  lane_be;
    logic [31:0] lane_wd, shifted, load_v, wb_n;
    logic [7:0]  byte_v, ctrl_n;
    logic [15:0] half_v;
    logic [4:0]  vec_n;

    assign is_byte = control_in[4:3] == 2'b00;
    assign is_half = control_in[4:3] == 2'b01;
    assign sx      = control_in[5];
    assign aligned = is_byte | (is_half & ~alu_in[0]) | (~is_byte & ~is_half & alu_in[1:0] == 2'b00);
    assign access  = ~control_in[0] & (control_in[1] | control_in[2]);
    assign mem_op  = access & vector_ex_in == 5'd0 & aligned;
    assign lane_be = is_byte ? 4'b0001 << alu_in[1:0] : is_half ? (alu_in[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign lane_wd = is_byte ? {4{sw_in[7:0]}} : is_half ? {2{sw_in[15:0]}} : sw_in;
    assign shifted = dmem_rdata >> {alu_in[1:0], 3'b000};
    assign byte_v  = shifted[7:0];
    assign half_v  = alu_in[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    assign load_v  = is_byte ? {{24{sx & byte_v[7]}}, byte_v} :
                     is_half ? {{16{sx & half_v[15]}}, half_v} : dmem_rdata;
    // Only meaningful in WAIT: this is the last cycle the transfer may run without an ack.
    assign timeout   = cnt_q == 8'(TIMEOUT - 1);
    // A flush seen on any WAIT cycle turns the eventual result into a bubble.
    assign flush_now = mem_flush | (state_q == WAIT & flush_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        flush_d   = flush_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        wb_d      = wb_q;
        ctrl_d    = ctrl_q;
        rd_d      = rd_q;
        vec_d     = vec_q;
        pc_d      = pc_q;
        stall_out = 1'b0;
        take      = 1'b0;
        bub       = 1'b0;
        vec_n     = 5'd0;
        ctrl_n    = control_in;
        wb_n      = alu_in;
        if (state_q == IDLE) begin
            stall_out = mem_op;
            if (mem_op) begin
                state_d = WAIT;
                cnt_d   = 8'd0;
                flush_d = 1'b0;
                req_d   = 1'b1;
                we_d    = control_in[2];
                addr_d  = {alu_in[31:2], 2'b00};
                wdata_d = lane_wd;
                be_d    = lane_be;
                bub     = 1'b1;
            end else begin
                take   = 1'b1;
                vec_n  = vector_ex_in != 5'd0 ? vector_ex_in : (access & ~aligned) ? (control_in[1] ? 5'd4 : 5'd5) : 5'd0;
                ctrl_n = vec_n != 5'd0 ? control_in & 8'hB9 : control_in;
            end
        end else begin
            cnt_d     = cnt_q + 8'd1;
            flush_d   = flush_q | mem_flush;
            stall_out = ~dmem_ack & ~timeout;
            if (dmem_ack | timeout) begin
                state_d = IDLE;
                req_d   = 1'b0;
                take    = 1'b1;
                vec_n   = dmem_ack ? 5'd0 : 5'd7;
                ctrl_n  = dmem_ack ? control_in : control_in & 8'hB9;
                wb_n    = (dmem_ack & control_in[1]) ? load_v : alu_in;
            end
        end
        if (bub | (take & flush_now)) begin
            wb_d   = 32'd0;
            ctrl_d = 8'h01;
            rd_d   = 5'd0;
            vec_d  = 5'd0;
            pc_d   = 32'd0;
        end else if (take) begin
            wb_d   = wb_n;
            ctrl_d = ctrl_n;
            rd_d   = regdst_in;
            vec_d  = vec_n;
            pc_d   = pc_in;
        end
        if (reset) stall_out = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            flush_q <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            wb_q    <= 32'd0;
            ctrl_q  <= 8'h01;
            rd_q    <= 5'd0;
            vec_q   <= 5'd0;
            pc_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flush_q <= flush_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            wb_q    <= wb_d;
            ctrl_q  <= ctrl_d;
            rd_q    <= rd_d;
            vec_q   <= vec_d;
            pc_q    <= pc_d;
        end
    end

    assign dmem_req       = req_q;
    assign dmem_we        = we_q;
    assign dmem_addr      = addr_q;
    assign dmem_wdata     = wdata_q;
    assign dmem_be        = be_q;
    assign wb_data_out    = wb_q;
    assign control_out    = ctrl_q;
    assign regdst_out     = rd_q;
    assign vector_mem_out = vec_q;
    assign pc_out         = pc_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized and directed self-checking bench for mem_stage against a per-instruction model
module tb_mem_stage;
    localparam int TO = 16;

    logic        clk = 1'b0, reset;
    logic [7:0]  control_in;
    logic [31:0] alu_in, sw_in, pc_in, dmem_rdata;
    logic [4:0]  regdst_in, vector_ex_in;
    logic        mem_flush, dmem_ack;
    logic        stall_out, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, wb_data_out, pc_out;
    logic [3:0]  dmem_be;
    logic [7:0]  control_out;
    logic [4:0]  regdst_out, vector_mem_out;

    mem_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .control_in(control_in), .alu_in(alu_in), .sw_in(sw_in),
        .regdst_in(regdst_in), .vector_ex_in(vector_ex_in), .pc_in(pc_in), .mem_flush(mem_flush),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall_out(stall_out), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .wb_data_out(wb_data_out), .control_out(control_out), .regdst_out(regdst_out),
        .vector_mem_out(vector_mem_out), .pc_out(pc_out)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0, stall_cnt = 0;

    typedef struct {
        logic [31:0] wb;
        logic [7:0]  c;
        logic [4:0]  rd;
        logic [4:0]  v;
        logic [31:0] pc;
    } res_t;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", n, a, e, $time);
        end
    endtask

    function automatic res_t mk(input logic [31:0] wb, input logic [7:0] c, input logic [4:0] rd,
                                input logic [4:0] v, input logic [31:0] pc);
        res_t r;
        r.wb = wb; r.c = c; r.rd = rd; r.v = v; r.pc = pc;
        return r;
    endfunction

    task automatic check_out(input string tag, input res_t e);
        chk({tag, ".wb"}, wb_data_out, e.wb);
        chk({tag, ".ctrl"}, {24'd0, control_out}, {24'd0, e.c});
        chk({tag, ".rd"}, {27'd0, regdst_out}, {27'd0, e.rd});
        chk({tag, ".vec"}, {27'd0, vector_mem_out}, {27'd0, e.v});
        chk({tag, ".pc"}, pc_out, e.pc);
    endtask

    // Load data as seen by the register file: pick the addressed lane, then extend.
    function automatic logic [31:0] load_val(input logic [7:0] c, input logic [31:0] alu, input logic [31:0] rdata);
        int unsigned b, h;
        b = (rdata >> (8 * alu[1:0])) & 32'hFF;
        h = (rdata >> (16 * alu[1])) & 32'hFFFF;
        if (c[4:3] == 2'b00) return (c[5] && b >= 128) ? b + 32'hFFFF_FF00 : b;
        if (c[4:3] == 2'b01) return (c[5] && h >= 32768) ? h + 32'hFFFF_0000 : h;
        return rdata;
    endfunction

    // One instruction from issue to retirement. ack_at: WAIT cycle carrying the ack (0 or >TO = never).
    // flush_idle: flush on a single-cycle instruction; flush_at: WAIT cycle with mem_flush.
    task automatic run(input logic [7:0] c, input logic [31:0] alu, input logic [31:0] sw, input logic [4:0] rd,
                       input logic [4:0] v, input logic [31:0] pc, input int ack_at, input bit flush_idle,
                       input int flush_at, input logic [31:0] rdata);
        bit   aligned, access, is_mem, flushed, done, ack;
        res_t e;
        logic [4:0] ev;
        aligned = c[4:3] == 2'b00 ? 1'b1 : c[4:3] == 2'b01 ? !alu[0] : alu[1:0] == 2'b00;
        access  = !c[0] && (c[1] || c[2]);
        is_mem  = access && v == 0 && aligned;
        control_in = c; alu_in = alu; sw_in = sw; regdst_in = rd; vector_ex_in = v; pc_in = pc;
        dmem_ack = 1'b0; dmem_rdata = $urandom;
        mem_flush = !is_mem && flush_idle;
        stall_cnt = 0;
        #1;
        chk("stall_issue", {31'd0, stall_out}, {31'd0, is_mem});
        if (stall_out) stall_cnt++;
        @(posedge clk); #1;
        mem_flush = 1'b0;
        if (!is_mem) begin
            ev = v != 0 ? v : (access && !aligned) ? (c[1] ? 5'd4 : 5'd5) : 5'd0;
            e  = flush_idle ? mk(0, 8'h01, 0, 0, 0) : mk(alu, ev != 0 ? c & 8'hB9 : c, rd, ev, pc);
            check_out("single", e);
            chk("single.req", {31'd0, dmem_req}, 0);
        end else begin
            chk("req_up", {31'd0, dmem_req}, 1);
            chk("addr", dmem_addr, {alu[31:2], 2'b00});
            chk("we", {31'd0, dmem_we}, {31'd0, c[2]});
            if (c[2]) begin
                chk("be", {28'd0, dmem_be}, c[4:3] == 2'b00 ? 32'd1 << alu[1:0] :
                                            c[4:3] == 2'b01 ? (alu[1] ? 32'hC : 32'h3) : 32'hF);
                chk("wdata", dmem_wdata, c[4:3] == 2'b00 ? {4{sw[7:0]}} :
                                         c[4:3] == 2'b01 ? {2{sw[15:0]}} : sw);
            end
            chk("entry_bubble", {24'd0, control_out}, 32'h01);
            flushed = 0; done = 0;
            for (int k = 1; k <= TO && !done; k++) begin
                ack = k == ack_at;
                flushed |= k == flush_at;
                dmem_ack = ack;
                dmem_rdata = ack ? rdata : $urandom;
                mem_flush = k == flush_at;
                #1;
                chk("stall_wait", {31'd0, stall_out}, {31'd0, !(ack || k == TO)});
                chk("req_held", {31'd0, dmem_req}, 1);
                if (stall_out) stall_cnt++;
                @(posedge clk); #1;
                dmem_ack = 1'b0; mem_flush = 1'b0;
                if (ack || k == TO) begin
                    done = 1;
                    e = flushed ? mk(0, 8'h01, 0, 0, 0) :
                        ack ? mk(c[1] ? load_val(c, alu, rdata) : alu, c, rd, 0, pc) : mk(alu, c & 8'hB9, rd, 7, pc);
                    check_out(ack ? "ack" : "timeout", e);
                    chk("req_down", {31'd0, dmem_req}, 0);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; control_in = 8'h01; alu_in = 0; sw_in = 0; regdst_in = 0; vector_ex_in = 0;
        pc_in = 0; mem_flush = 0; dmem_ack = 0; dmem_rdata = 0;
        #12;
        check_out("reset", mk(0, 8'h01, 0, 0, 0));
        chk("reset.req", {31'd0, dmem_req}, 0);
        chk("reset.stall", {31'd0, stall_out}, 0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;

        run(8'h40, 32'h1234, 0, 5'd5, 0, 32'h400, 0, 0, 0, 0);
        chk("alu.wb", wb_data_out, 32'h1234);
        chk("alu.rd", {27'd0, regdst_out}, 5);
        chk("alu.stalls", stall_cnt, 0);

        run(8'hE2, 32'h103, 0, 5'd7, 0, 32'h404, 3, 0, 0, 32'h80FF_FF00);
        chk("lb.wb", wb_data_out, 32'hFFFF_FF80);
        chk("lb.stalls", stall_cnt, 3);
        chk("lb.addr", dmem_addr, 32'h100);

        run(8'h0C, 32'h202, 32'hABCD_5678, 0, 0, 32'h408, 1, 0, 0, 0);
        chk("sh.we", {31'd0, dmem_we}, 1);
        chk("sh.be", {28'd0, dmem_be}, 4'b1100);
        chk("sh.wdata", dmem_wdata, 32'h5678_5678);

        run(8'h52, 32'h301, 0, 5'd3, 0, 32'h40C, 0, 0, 0, 0);
        chk("lw_mis.vec", {27'd0, vector_mem_out}, 4);
        chk("lw_mis.c6", {31'd0, control_out[6]}, 0);
        run(8'h14, 32'h302, 0, 0, 0, 32'h410, 0, 0, 0, 0);
        chk("sw_mis.vec", {27'd0, vector_mem_out}, 5);

        run(8'h52, 32'h300, 0, 5'd9, 0, 32'h414, 0, 0, 0, 0);
        chk("to.vec", {27'd0, vector_mem_out}, 7);
        chk("to.stalls", stall_cnt, TO);
        run(8'h52, 32'h300, 0, 5'd9, 0, 32'h418, TO, 0, 0, 32'hCAFE_F00D);
        chk("ack16.vec", {27'd0, vector_mem_out}, 0);
        chk("ack16.wb", wb_data_out, 32'hCAFE_F00D);

        run(8'h52, 32'h600, 0, 5'd2, 0, 32'h41C, 4, 0, 2, 32'h1111_2222);
        chk("flush.ctrl", {24'd0, control_out}, 32'h01);

        control_in = 8'h52; alu_in = 32'h500; vector_ex_in = 0;
        @(posedge clk); #1;
        chk("rst_mid.req_up", {31'd0, dmem_req}, 1);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid.req", {31'd0, dmem_req}, 0);
        chk("rst_mid.stall", {31'd0, stall_out}, 0);
        check_out("rst_mid", mk(0, 8'h01, 0, 0, 0));
        control_in = 8'h01;
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 120; i++) begin
            logic [7:0]  c;
            logic [31:0] alu;
            logic [4:0]  v;
            int          ack_at, flush_at;
            c = 8'($urandom);
            c[0] = $urandom_range(0, 4) == 0;
            if ($urandom_range(0, 2) != 0) c[2:1] = 2'($urandom_range(1, 2));
            alu = $urandom;
            if ($urandom_range(0, 2) != 0) alu[1:0] = 2'b00;
            v = $urandom_range(0, 7) == 0 ? 5'($urandom_range(1, 31)) : 5'd0;
            ack_at = $urandom_range(1, TO + 3);
            if (ack_at > TO) ack_at = 0;
            flush_at = $urandom_range(0, 4) == 0 ? $urandom_range(1, TO) : 0;
            run(c, alu, $urandom, 5'($urandom), v, $urandom, ack_at, $urandom_range(0, 5) == 0, flush_at, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
